fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
IF-stage PC sequencer for the 5-stage DLX pipeline; the consuming end of the decode-stage jump/branch resolver's takeBranch/outputPC redirect. Holds the PC and issues one-outstanding instruction-memory fetches with a ready handshake. Applies redirects, squashes the wrong-path fetch, and drives the IF/ID pipeline register, with a one-entry skid buffer for decode stalls. No branch delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
ADDR_W, 32, PC/address width. Fixed at 32 for DLX.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
redirect_valid  in  1  takeBranch from decode-stage branch unit
redirect_pc  in  32  outputPC from decode-stage branch unit
stall_id  in  1  hazard unit: hold IF/ID register
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  imem_rdata valid this cycle; completes request
imem_rdata  in  32  fetched instruction
if_id_instruction  out  32  instruction to decode
if_id_pc_plus_four  out  32  fetch address + 4 (feeds pc_plus_four of branch unit)
if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (rst_n=0 at edge, regardless of state or outstanding request): pc<=RESET_PC; state<=IDLE; if_id_instruction<=0, if_id_pc_plus_four<=0, if_id_valid<=0; skid empty; imem_req=0. An in-flight memory response after reset is ignored.
- imem_addr = pc whenever imem_req=1; addr and req held stable until a cycle with imem_ready=1.
- States:
  - IDLE: imem_req=0; next FETCH. Exactly one bubble cycle after reset release.
  - FETCH: imem_req=1, addr=pc.
  - HOLD: response captured into skid during stall; imem_req=0.
  - DRAIN: redirect arrived with request outstanding; imem_req=1 at old address until ready; data discarded.
- Redirect priority: redirect_valid honored only when stall_id=0; ignored when stall_id=1. When honored:
  - pc<=redirect_pc with bits[1:0] forced to 0.
  - if_id_valid<=0, squashing the wrong-path slot.
  - Skid cleared.
  - From FETCH with imem_ready=1: data dropped, state stays FETCH at new pc.
  - From FETCH with imem_ready=0: state DRAIN.
  - From HOLD: state FETCH.
- FETCH, imem_ready=1, no redirect, stall_id=0: if_id_instruction<=imem_rdata; if_id_pc_plus_four<=pc+4; if_id_valid<=1; pc<=pc+4. Back-to-back fetch: one instruction per cycle if ready stays high.
- FETCH, imem_ready=1, stall_id=1: IF/ID unchanged; skid<={rdata, pc+4}; pc<=pc+4; state HOLD.
- FETCH, imem_ready=0, stall_id=0: if_id_valid<=0 (bubble); IF/ID data fields hold.
- FETCH, imem_ready=0, stall_id=1: IF/ID unchanged.
- HOLD, stall_id=0, no redirect: IF/ID<=skid, valid=1; state FETCH.
- DRAIN: on imem_ready=1, state FETCH (pc already redirected). A second honored redirect in DRAIN updates pc only; state stays DRAIN.
- stall_id=1 never changes any IF/ID field, including valid.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr: after IDLE bubble, addresses 0,4,8 fetched on consecutive cycles; IF/ID shows pc_plus_four 4,8,12 with valid=1.
- Hold rst_n low 3 cycles mid-stream with a request outstanding: all outputs 0, imem_req=0. First request after release is at RESET_PC; late ready is ignored.
- Redirect with redirect_pc=32'h0000_0103, ready=1 same cycle at pc=0x10: next cycle if_id_valid=0 and imem_addr=0x100; following cycle IF/ID pc_plus_four=0x104.
- Ready delayed 3 cycles, redirect to 0x200 in the first wait cycle: addr held at old pc until ready, returned data never appears in IF/ID, then imem_addr=0x200.
- stall_id high 4 cycles while a fetch returns 0xDEADBEEF: IF/ID frozen, imem_req drops. On release, IF/ID=0xDEADBEEF with valid=1 and no instruction lost or duplicated; redirect_valid pulsed during the stall is ignored.
- Redirect to 0xFFFF_FFFC with ready=1: the next fetch after 0xFFFF_FFFC is at 0x0000_0000, and the IF/ID entry for the 0xFFFF_FFFC fetch has pc_plus_four=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage PC sequencer for the 5-stage DLX pipeline.
//
// Holds the fetch PC, issues one-outstanding instruction-memory requests,
// applies decode-stage redirects (takeBranch/outputPC) without a delay slot,
// squashes the wrong-path slot and drives the IF/ID pipeline register.
// A one-entry skid buffer keeps a response that returns while decode stalls.
//
// Ports:
//   clk                 pipeline clock, all state updates on the rising edge
//   rst_n               synchronous active-low reset
//   redirect_valid      takeBranch from the decode-stage branch unit
//   redirect_pc         outputPC from the decode-stage branch unit
//   stall_id            hazard unit: hold the IF/ID register
//   imem_req            fetch request
//   imem_addr           fetch address, word aligned
//   imem_ready          imem_rdata valid this cycle; completes the request
//   imem_rdata          fetched instruction
//   if_id_instruction   instruction to decode
//   if_id_pc_plus_four  fetch address + 4
//   if_id_valid         IF/ID holds a real instruction (0 = bubble)
module fetch_pc_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall_id,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_instruction,
    output logic [ADDR_W-1:0] if_id_pc_plus_four,
    output logic              if_id_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_imem_req;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_if_id_instruction;
    logic [ADDR_W-1:0] r_if_id_pc_plus_four;
    logic              r_if_id_valid;
    logic [31:0]       r_skid_instruction;
    logic [ADDR_W-1:0] r_skid_pc_plus_four;

    logic [ADDR_W-1:0] w_pc_plus_four;
    logic [ADDR_W-1:0] w_redirect_target;
    logic              w_take_redirect;

    // pc+4 wraps modulo 2^ADDR_W by width truncation
    assign w_pc_plus_four    = r_pc + ADDR_W'(4);
    assign w_redirect_target = redirect_pc & ~ADDR_W'(3);
    // a stalled decode stage cannot own a resolved branch, so ignore it
    assign w_take_redirect   = redirect_valid && !stall_id;

    assign imem_req           = r_imem_req;
    assign imem_addr          = r_imem_addr;
    assign if_id_instruction  = r_if_id_instruction;
    assign if_id_pc_plus_four = r_if_id_pc_plus_four;
    assign if_id_valid        = r_if_id_valid;

    // r_imem_addr tracks r_pc except in DRAIN, where it keeps the address of
    // the request still outstanding while r_pc already holds the redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state              <= ST_IDLE;
            r_pc                 <= RESET_PC;
            r_imem_req           <= 1'b0;
            r_imem_addr          <= RESET_PC;
            r_if_id_instruction  <= '0;
            r_if_id_pc_plus_four <= '0;
            r_if_id_valid        <= 1'b0;
            r_skid_instruction   <= '0;
            r_skid_pc_plus_four  <= '0;
        end else begin
            if (w_take_redirect) begin
                r_pc                <= w_redirect_target;
                r_if_id_valid       <= 1'b0;
                r_skid_instruction  <= '0;
                r_skid_pc_plus_four <= '0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                    if (w_take_redirect) begin
                        r_imem_addr <= w_redirect_target;
                    end else begin
                        r_imem_addr <= r_pc;
                        if (!stall_id) begin
                            r_if_id_valid <= 1'b0;
                        end
                    end
                end

                ST_FETCH: begin
                    if (w_take_redirect) begin
                        if (imem_ready) begin
                            // wrong-path data dropped, refetch at target
                            r_imem_addr <= w_redirect_target;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (imem_ready && !stall_id) begin
                        r_if_id_instruction  <= imem_rdata;
                        r_if_id_pc_plus_four <= w_pc_plus_four;
                        r_if_id_valid        <= 1'b1;
                        r_pc                 <= w_pc_plus_four;
                        r_imem_addr          <= w_pc_plus_four;
                    end else if (imem_ready) begin
                        r_skid_instruction  <= imem_rdata;
                        r_skid_pc_plus_four <= w_pc_plus_four;
                        r_pc                <= w_pc_plus_four;
                        r_imem_addr         <= w_pc_plus_four;
                        r_imem_req          <= 1'b0;
                        r_state             <= ST_HOLD;
                    end else if (!stall_id) begin
                        r_if_id_valid <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (w_take_redirect) begin
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_redirect_target;
                        r_state     <= ST_FETCH;
                    end else if (!stall_id) begin
                        r_if_id_instruction  <= r_skid_instruction;
                        r_if_id_pc_plus_four <= r_skid_pc_plus_four;
                        r_if_id_valid        <= 1'b1;
                        r_imem_req           <= 1'b1;
                        r_imem_addr          <= r_pc;
                        r_state              <= ST_FETCH;
                    end
                end

                ST_DRAIN: begin
                    if (!stall_id) begin
                        r_if_id_valid <= 1'b0;
                    end
                    if (imem_ready) begin
                        // response belongs to the old path and is discarded
                        r_state     <= ST_FETCH;
                        r_imem_addr <= w_take_redirect ? w_redirect_target : r_pc;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: expected IF/ID entries are queued
// when a fetch is driven to completion and popped when decode consumes them.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_id;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus_four;
    logic        if_id_valid;

    logic [31:0] salt;
    logic        ovr_en;
    logic [31:0] ovr_data;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec;
    int   n_err;

    fetch_pc_unit #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .stall_id          (stall_id),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus_four(if_id_pc_plus_four),
        .if_id_valid       (if_id_valid)
    );

    // memory returns a salted copy of the address unless overridden
    assign imem_rdata = ovr_en ? ovr_data : (imem_addr ^ salt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall_id       = 1'b0;
        imem_ready     = 1'b0;
        ovr_en         = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall_id = 1'b0;
        imem_ready = 1'b1; ovr_en = 1'b0; ovr_data = '0; salt = '0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
        n_vec++; if (if_id_instruction !== 32'h0) begin n_err++; $display("FAIL rst_instr got=%h exp=0", if_id_instruction); end
        n_vec++; if (if_id_pc_plus_four !== 32'h0) begin n_err++; $display("FAIL rst_pc4 got=%h exp=0", if_id_pc_plus_four); end
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rst_first_req got=%b exp=1", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_first_addr got=%h exp=0", imem_addr); end
        n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_bubble got=%b exp=0", if_id_valid); end
        exp_q.push_back('{instr: 32'h0 ^ salt, pc4: 32'h4});
    endtask

    // continues the stream started by test_reset with ready tied high
    task automatic test_sequential();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_vec++; if (imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, 32'(4 * k)); end
            n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid got=%b exp=1", if_id_valid); end
            if (exp_q.size() == 0) begin
                n_vec++; n_err++; $display("FAIL seq_sb got=empty exp=entry");
            end else begin
                e = exp_q.pop_front();
                n_vec++; if (if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL seq_ifid got=%h/%h exp=%h/%h", if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
            end
            exp_q.push_back('{instr: 32'(4 * k) ^ salt, pc4: 32'(4 * k + 4)});
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        salt = 32'hC0DE_0000;
        imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL mid_outstanding got=%b/%h exp=1/00000008", imem_req, imem_addr); end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_req got=%b exp=0", imem_req); end
            n_vec++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc_plus_four !== 32'h0) begin n_err++; $display("FAIL mid_rst_ifid got=%b/%h/%h exp=0/0/0", if_id_valid, if_id_instruction, if_id_pc_plus_four); end
            if (i == 2) begin
                rst_n = 1'b1;
                imem_ready = 1'b1;
            end
        end
        exp_q.delete();
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL mid_restart got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL mid_late_ready got=%b exp=0", if_id_valid); end
        imem_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin n_err++; $display("FAIL mid_wait got=%h/%b exp=00000000/0", imem_addr, if_id_valid); end
        imem_ready = 1'b1;
        exp_q.push_back('{instr: 32'h0 ^ salt, pc4: 32'h4});
        @(negedge clk);
        n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid got=%b exp=1", if_id_valid); end
        e = exp_q.pop_front();
        n_vec++; if (if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL mid_ifid got=%h/%h exp=%h/%h", if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
    endtask

    task automatic test_redirect_ready();
        do_reset();
        salt = 32'h1234_0000;
        imem_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            n_vec++; if (imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL rdr_addr got=%h exp=%h", imem_addr, 32'(4 * k)); end
            if (k >= 1) begin
                n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL rdr_valid got=%b exp=1", if_id_valid); end
                e = exp_q.pop_front();
                n_vec++; if (if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL rdr_ifid got=%h/%h exp=%h/%h", if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
            end
            if (k < 4) begin
                exp_q.push_back('{instr: 32'(4 * k) ^ salt, pc4: 32'(4 * k + 4)});
            end else begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0103;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rdr_squash got=%b exp=0", if_id_valid); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL rdr_target got=%b/%h exp=1/00000100", imem_req, imem_addr); end
        exp_q.push_back('{instr: 32'h100 ^ salt, pc4: 32'h104});
        @(negedge clk);
        n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL rdr_new_valid got=%b exp=1", if_id_valid); end
        e = exp_q.pop_front();
        n_vec++; if (if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL rdr_new_ifid got=%h/%h exp=%h/%h", if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
        n_vec++; if (imem_addr !== 32'h104) begin n_err++; $display("FAIL rdr_next_addr got=%h exp=00000104", imem_addr); end
    endtask

    task automatic test_drain();
        do_reset();
        salt = 32'h7700_0000;
        imem_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL drn_addr0 got=%h exp=0", imem_addr); end
        exp_q.push_back('{instr: 32'h0 ^ salt, pc4: 32'h4});
        @(negedge clk);
        n_vec++; if (imem_addr !== 32'h4 || if_id_valid !== 1'b1) begin n_err++; $display("FAIL drn_pre got=%h/%b exp=00000004/1", imem_addr, if_id_valid); end
        e = exp_q.pop_front();
        n_vec++; if (if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL drn_pre_ifid got=%h/%h exp=%h/%h", if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL drn_hold got=%b/%h exp=1/00000004", imem_req, imem_addr); end
            n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL drn_bubble got=%b exp=0", if_id_valid); end
            if (i == 2) imem_ready = 1'b1;
        end
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL drn_target got=%b/%h exp=1/00000200", imem_req, imem_addr); end
        n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL drn_discard got=%b exp=0", if_id_valid); end
        exp_q.push_back('{instr: 32'h200 ^ salt, pc4: 32'h204});
        @(negedge clk);
        n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL drn_valid got=%b exp=1", if_id_valid); end
        e = exp_q.pop_front();
        n_vec++; if (if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL drn_ifid got=%h/%h exp=%h/%h", if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
    endtask

    task automatic test_stall();
        do_reset();
        salt = 32'h0055_0000;
        imem_ready = 1'b1;
        @(negedge clk);
        exp_q.push_back('{instr: 32'h0 ^ salt, pc4: 32'h4});
        @(negedge clk);
        n_vec++; if (imem_addr !== 32'h4 || if_id_valid !== 1'b1) begin n_err++; $display("FAIL stl_pre got=%h/%b exp=00000004/1", imem_addr, if_id_valid); end
        stall_id = 1'b1;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        exp_q.push_back('{instr: 32'hDEAD_BEEF, pc4: 32'h8});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ovr_en = 1'b0;
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stl_req got=%b exp=0", imem_req); end
            n_vec++; if (if_id_valid !== 1'b1 || if_id_instruction !== exp_q[0].instr || if_id_pc_plus_four !== exp_q[0].pc4) begin n_err++; $display("FAIL stl_frozen got=%b/%h/%h exp=1/%h/%h", if_id_valid, if_id_instruction, if_id_pc_plus_four, exp_q[0].instr, exp_q[0].pc4); end
            redirect_valid = (i == 1);
            redirect_pc    = 32'h0000_0300;
            if (i == 3) begin
                stall_id = 1'b0;
                e = exp_q.pop_front();
            end
        end
        @(negedge clk);
        n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL stl_rel_valid got=%b exp=1", if_id_valid); end
        e = exp_q.pop_front();
        n_vec++; if (if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL stl_skid got=%h/%h exp=%h/%h", if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL stl_resume got=%b/%h exp=1/00000008", imem_req, imem_addr); end
        exp_q.push_back('{instr: 32'h8 ^ salt, pc4: 32'hC});
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++; if (if_id_valid !== 1'b1 || if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL stl_next got=%b/%h/%h exp=1/%h/%h", if_id_valid, if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
        n_vec++; if (imem_addr !== 32'hC) begin n_err++; $display("FAIL stl_next_addr got=%h exp=0000000c", imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        salt = 32'h0BAD_0000;
        imem_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++; if (imem_addr !== 32'hFFFF_FFFC || if_id_valid !== 1'b0) begin n_err++; $display("FAIL wrp_target got=%h/%b exp=fffffffc/0", imem_addr, if_id_valid); end
        exp_q.push_back('{instr: 32'hFFFF_FFFC ^ salt, pc4: 32'h0});
        @(negedge clk);
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrp_addr got=%h exp=00000000", imem_addr); end
        e = exp_q.pop_front();
        n_vec++; if (if_id_valid !== 1'b1 || if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL wrp_ifid got=%b/%h/%h exp=1/%h/%h", if_id_valid, if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
        exp_q.push_back('{instr: 32'h0 ^ salt, pc4: 32'h4});
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++; if (if_id_valid !== 1'b1 || if_id_instruction !== e.instr || if_id_pc_plus_four !== e.pc4) begin n_err++; $display("FAIL wrp_next got=%b/%h/%h exp=1/%h/%h", if_id_valid, if_id_instruction, if_id_pc_plus_four, e.instr, e.pc4); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_sequential();
        test_reset_midstream();
        test_redirect_ready();
        test_drain();
        test_stall();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
